// File: rtl/fetch_unit_if.sv
// Instruction-cache read channel between the fetch stage and the cache.
interface fetch_unit_if;
  logic        icache_re;
  logic [15:0] icache_addr;
  logic        icache_rdy;
  logic [15:0] icache_data;

  // Fetch stage side: issues the read and consumes the returned word.
  modport master (
    output icache_re,
    output icache_addr,
    input  icache_rdy,
    input  icache_data
  );

  // Cache side: accepts the read and returns the word.
  modport slave (
    input  icache_re,
    input  icache_addr,
    output icache_rdy,
    output icache_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reads the cache at the current PC, rides out
// multi-cycle misses, owns the IF/ID register and drives the PC write enable.
module fetch_unit (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  currPC,
  input  logic [15:0]  PCIncOut,
  input  logic         stall,
  input  logic         flush,
  fetch_unit_if.master icache,
  output logic         pc_we,
  output logic [15:0]  IF_ID_Inst,
  output logic [15:0]  IF_ID_PCInc,
  output logic         IF_ID_valid,
  output logic         if_hlt,
  output logic [15:0]  miss_count
);

  localparam logic [15:0] NOP_INST = 16'h0000;
  localparam logic [3:0]  HLT_OPC  = 4'hF;

  typedef enum logic [1:0] {FETCH, MISS_WAIT, BUFFERED, HALTED} state_t;

  state_t      state, state_nxt;
  logic [15:0] miss_addr, miss_pcinc, buf_inst;
  logic        squash;

  logic        rdy;
  logic        data_hlt, buf_hlt;
  logic        pc_we_raw, re_raw;
  logic [15:0] addr_sel;
  logic        ifid_ld, ifid_valid_nxt;
  logic [15:0] ifid_inst_nxt, ifid_pcinc_nxt;
  logic        cap_miss, ld_buf, squash_set, squash_clr, cnt_inc;

  assign rdy      = icache.icache_rdy;
  assign data_hlt = (icache.icache_data[15:12] == HLT_OPC);
  assign buf_hlt  = (buf_inst[15:12] == HLT_OPC);

  // State register; reset drops any outstanding miss and returns to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state selection with flush taking precedence over stall over the cache response.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: begin
        if (flush || stall) state_nxt = FETCH;
        else if (rdy)       state_nxt = data_hlt ? HALTED : FETCH;
        else                state_nxt = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (rdy) begin
          if (flush || squash) state_nxt = FETCH;
          else if (stall)      state_nxt = BUFFERED;
          else                 state_nxt = data_hlt ? HALTED : FETCH;
        end
      end
      BUFFERED: begin
        if (flush)       state_nxt = FETCH;
        else if (!stall) state_nxt = buf_hlt ? HALTED : FETCH;
      end
      HALTED: begin
        if (flush) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Per-state outputs: cache request, PC enable, IF/ID load value and side-register controls.
  always_comb begin
    pc_we_raw      = 1'b0;
    re_raw         = 1'b0;
    addr_sel       = currPC;
    ifid_ld        = 1'b0;
    ifid_inst_nxt  = NOP_INST;
    ifid_pcinc_nxt = 16'h0000;
    ifid_valid_nxt = 1'b0;
    cap_miss       = 1'b0;
    ld_buf         = 1'b0;
    squash_set     = 1'b0;
    squash_clr     = 1'b0;
    cnt_inc        = 1'b0;
    unique case (state)
      FETCH: begin
        re_raw   = !stall;
        addr_sel = currPC;
        if (flush) begin
          ifid_ld   = 1'b1;
          pc_we_raw = 1'b1;
        end else if (stall) begin
          pc_we_raw = 1'b0;
        end else if (rdy) begin
          ifid_ld        = 1'b1;
          ifid_inst_nxt  = icache.icache_data;
          ifid_pcinc_nxt = PCIncOut;
          ifid_valid_nxt = 1'b1;
          pc_we_raw      = 1'b1;
        end else begin
          ifid_ld  = 1'b1;
          cap_miss = 1'b1;
          cnt_inc  = 1'b1;
        end
      end
      MISS_WAIT: begin
        re_raw   = 1'b1;
        addr_sel = miss_addr;
        if (flush) begin
          ifid_ld    = 1'b1;
          pc_we_raw  = 1'b1;
          squash_set = !rdy;
          squash_clr = rdy;
        end else if (rdy && squash) begin
          squash_clr = 1'b1;
          ifid_ld    = !stall;
        end else if (rdy && stall) begin
          ld_buf = 1'b1;
        end else if (rdy) begin
          ifid_ld        = 1'b1;
          ifid_inst_nxt  = icache.icache_data;
          ifid_pcinc_nxt = miss_pcinc;
          ifid_valid_nxt = 1'b1;
          pc_we_raw      = 1'b1;
        end else begin
          ifid_ld = !stall;
        end
      end
      BUFFERED: begin
        addr_sel = miss_addr;
        if (flush) begin
          ifid_ld   = 1'b1;
          pc_we_raw = 1'b1;
        end else if (!stall) begin
          ifid_ld        = 1'b1;
          ifid_inst_nxt  = buf_inst;
          ifid_pcinc_nxt = miss_pcinc;
          ifid_valid_nxt = 1'b1;
          pc_we_raw      = 1'b1;
        end
      end
      HALTED: begin
        ifid_ld   = flush || !stall;
        pc_we_raw = flush;
      end
      default: begin
        ifid_ld = 1'b1;
      end
    endcase
  end

  // Combinational outputs are forced low while reset is held.
  assign pc_we              = pc_we_raw & rst_n;
  assign icache.icache_re   = re_raw & rst_n;
  assign icache.icache_addr = addr_sel;
  assign if_hlt             = (state == HALTED);

  // IF/ID pipeline register: loads an instruction or a bubble, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_Inst  <= NOP_INST;
      IF_ID_PCInc <= 16'h0000;
      IF_ID_valid <= 1'b0;
    end else if (ifid_ld) begin
      IF_ID_Inst  <= ifid_inst_nxt;
      IF_ID_PCInc <= ifid_pcinc_nxt;
      IF_ID_valid <= ifid_valid_nxt;
    end
  end

  // Miss bookkeeping: address/PC+1 of the missed fetch, stalled fill word, squash flag, saturating count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_addr  <= 16'h0000;
      miss_pcinc <= 16'h0000;
      buf_inst   <= NOP_INST;
      squash     <= 1'b0;
      miss_count <= 16'h0000;
    end else begin
      if (cap_miss) begin
        miss_addr  <= currPC;
        miss_pcinc <= PCIncOut;
      end
      if (ld_buf)          buf_inst <= icache.icache_data;
      if (squash_set)      squash   <= 1'b1;
      else if (squash_clr) squash   <= 1'b0;
      if (cnt_inc && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scripted cache responses with a small PC
// model and a scoreboard of instructions expected to arrive in IF/ID.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] currPC, PCIncOut;
  logic        stall, flush;
  logic        pc_we;
  logic [15:0] IF_ID_Inst, IF_ID_PCInc, miss_count;
  logic        IF_ID_valid, if_hlt;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .currPC      (currPC),
    .PCIncOut    (PCIncOut),
    .stall       (stall),
    .flush       (flush),
    .icache      (bus),
    .pc_we       (pc_we),
    .IF_ID_Inst  (IF_ID_Inst),
    .IF_ID_PCInc (IF_ID_PCInc),
    .IF_ID_valid (IF_ID_valid),
    .if_hlt      (if_hlt),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] pc;
  logic [31:0] sb[$];
  logic        last_v = 1'b0;
  logic [31:0] last_w = 32'h0;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle, entered at a falling edge: drive inputs, check combinational
  // outputs, then check IF/ID validity after the rising edge; the PC model
  // advances to PC+1 when a non-flush cycle expects pc_we.
  task automatic applyStimulus(input logic s, input logic f, input logic r, input logic [15:0] d,
                               input logic exp_we, input logic exp_re, input logic [15:0] exp_addr,
                               input logic exp_valid);
    stall = s;
    flush = f;
    bus.icache_rdy  = r;
    bus.icache_data = d;
    currPC   = pc;
    PCIncOut = pc + 16'd1;
    #1;
    checkOutput("pc_we", {15'd0, pc_we}, {15'd0, exp_we});
    checkOutput("icache_re", {15'd0, bus.icache_re}, {15'd0, exp_re});
    if (exp_re) checkOutput("icache_addr", bus.icache_addr, exp_addr);
    @(posedge clk);
    #1;
    checkOutput("ifid_valid", {15'd0, IF_ID_valid}, {15'd0, exp_valid});
    if (exp_we && !f) pc = pc + 16'd1;
    @(negedge clk);
  endtask

  // Scoreboard monitor: every newly loaded valid IF/ID entry must match the oldest expected one.
  always @(posedge clk) begin
    #1;
    if (rst_n && IF_ID_valid && (!last_v || ({IF_ID_PCInc, IF_ID_Inst} != last_w))) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected", {15'd0, IF_ID_valid}, 16'd0);
      end else begin
        logic [31:0] w;
        w = sb.pop_front();
        checkOutput("sb_inst", IF_ID_Inst, w[15:0]);
        checkOutput("sb_pcinc", IF_ID_PCInc, w[31:16]);
      end
    end
    last_v = IF_ID_valid;
    last_w = {IF_ID_PCInc, IF_ID_Inst};
  end

  // Checks every output against its reset value while rst_n is low.
  task automatic checkReset(input string tag);
    checkOutput({tag, "_inst"}, IF_ID_Inst, 16'h0000);
    checkOutput({tag, "_pcinc"}, IF_ID_PCInc, 16'h0000);
    checkOutput({tag, "_valid"}, {15'd0, IF_ID_valid}, 16'd0);
    checkOutput({tag, "_hlt"}, {15'd0, if_hlt}, 16'd0);
    checkOutput({tag, "_pcwe"}, {15'd0, pc_we}, 16'd0);
    checkOutput({tag, "_re"}, {15'd0, bus.icache_re}, 16'd0);
    checkOutput({tag, "_mcnt"}, miss_count, 16'd0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Scripted scenarios.
  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    bus.icache_rdy = 1'b1; bus.icache_data = 16'h1111;
    pc = 16'd0; currPC = 16'd0; PCIncOut = 16'd1;
    #3;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back hits, one instruction per cycle.
    for (int i = 0; i < 5; i++) begin
      logic [15:0] d;
      d = 16'h1111 * 16'(i + 1);
      sb.push_back({pc + 16'd1, d});
      applyStimulus(1'b0, 1'b0, 1'b1, d, 1'b1, 1'b1, pc, 1'b1);
    end
    checkOutput("mcnt_hits", miss_count, 16'd0);

    // Three-cycle miss at PC 5.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0BAD, 1'b0, 1'b1, 16'd5, 1'b0);
    checkOutput("mcnt_first", miss_count, 16'd1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0BAD, 1'b0, 1'b1, 16'd5, 1'b0);
    sb.push_back({16'd6, 16'h6A6A});
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h6A6A, 1'b1, 1'b1, 16'd5, 1'b1);
    checkOutput("mcnt_after_fill", miss_count, 16'd1);

    // Flush in the first MISS_WAIT cycle; the fill is discarded.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0BAD, 1'b0, 1'b1, 16'd6, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0BAD, 1'b1, 1'b1, 16'd6, 1'b0);
    pc = 16'h0040;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0BAD, 1'b0, 1'b1, 16'd6, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b1, 16'd6, 1'b0);
    sb.push_back({16'h0041, 16'h7777});
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b1, 16'h0040, 1'b1);

    // Stall when the fill arrives: word parked in BUFFERED until stall drops.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0BAD, 1'b0, 1'b1, 16'h0041, 1'b0);
    checkOutput("mcnt_third", miss_count, 16'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h8888, 1'b0, 1'b1, 16'h0041, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0BAD, 1'b0, 1'b0, 16'h0000, 1'b0);
    sb.push_back({16'h0042, 16'h8888});
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0BAD, 1'b1, 1'b0, 16'h0000, 1'b1);

    // HLT fetch, five halted cycles, then a flush resumes fetching.
    sb.push_back({16'h0043, 16'hF000});
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hF000, 1'b1, 1'b1, 16'h0042, 1'b1);
    checkOutput("hlt_set", {15'd0, if_hlt}, 16'd1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("hlt_held", {15'd0, if_hlt}, 16'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b0);
    pc = 16'h0080;
    checkOutput("hlt_clear", {15'd0, if_hlt}, 16'd0);
    sb.push_back({16'h0081, 16'h1234});
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h0080, 1'b1);

    // Stall in FETCH holds IF/ID; flush in FETCH inserts a bubble.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("stall_hold", IF_ID_Inst, 16'h1234);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b1, 16'h0081, 1'b0);
    pc = 16'h0090;
    sb.push_back({16'h0091, 16'h2345});
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h2345, 1'b1, 1'b1, 16'h0090, 1'b1);

    // Asynchronous reset in the middle of a miss.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0BAD, 1'b0, 1'b1, 16'h0091, 1'b0);
    bus.icache_rdy = 1'b1; bus.icache_data = 16'hBEEF;
    #1;
    checkOutput("fill_we", {15'd0, pc_we}, 16'd1);
    rst_n = 1'b0;
    #1;
    checkReset("rst_miss");
    @(negedge clk);
    rst_n = 1'b1;
    pc = 16'd0;
    sb.push_back({16'd1, 16'h3456});
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h3456, 1'b1, 1'b1, 16'd0, 1'b1);

    // Asynchronous reset while halted.
    sb.push_back({16'd2, 16'hF001});
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hF001, 1'b1, 1'b1, 16'd1, 1'b1);
    checkOutput("hlt2_set", {15'd0, if_hlt}, 16'd1);
    bus.icache_rdy = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checkReset("rst_hlt");
    @(negedge clk);
    rst_n = 1'b1;
    pc = 16'd0;
    sb.push_back({16'd1, 16'h4567});
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h4567, 1'b1, 1'b1, 16'd0, 1'b1);

    checkOutput("sb_drain", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
